// File: rtl/mem_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage_pkg : shared widths, EXE->MEM bus layout and MEM state encoding    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package mem_stage_pkg;

   localparam int EXE_to_MEM_LEN = 112;
   localparam int MEM_to_WB_LEN  = 70;
   localparam int MEM_RF_LEN     = 38;
   localparam int DEST_LEN       = 5;

   // load_op bit positions
   localparam int c_LD_BYTE = 0;
   localparam int c_LD_HALF = 1;
   localparam int c_LD_WORD = 2;
   localparam int c_LD_ZEXT = 3;

   typedef struct packed {
      logic [31:0]         pc;
      logic                gr_we;
      logic [DEST_LEN-1:0] dest;
      logic [31:0]         alu_result;
      logic [31:0]         mem_sum;
      logic                mem_en;
      logic [3:0]          mem_we;
      logic [3:0]          load_op;
      logic                rfrom_mem;
   } exe_to_mem_t;

   // IDLE: empty, WAIT: memory op awaiting data_ok,
   // HOLD: response buffered while WB stalls, DONE: non-memory op ready to leave
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } mem_state_t;

   function automatic logic is_mem_op(input exe_to_mem_t f);
      return f.rfrom_mem | f.mem_en;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage_if : EXE/SRAM/WB handshake and bus bundle seen by the MEM stage    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic [EXE_to_MEM_LEN-1:0] EXE_to_MEM_BUS;
   logic                      EXE_to_MEM_valid;
   logic                      MEM_allowin;
   logic [31:0]               data_sram_rdata;
   logic                      data_sram_data_ok;
   logic                      WB_allowin;
   logic                      MEM_to_WB_valid;
   logic [MEM_to_WB_LEN-1:0]  MEM_to_WB_BUS;
   logic [MEM_RF_LEN-1:0]     MEM_RF_BUS;

   modport master (
      output EXE_to_MEM_BUS, EXE_to_MEM_valid, data_sram_rdata, data_sram_data_ok, WB_allowin,
      input  MEM_allowin, MEM_to_WB_valid, MEM_to_WB_BUS, MEM_RF_BUS
   );

   modport slave (
      input  EXE_to_MEM_BUS, EXE_to_MEM_valid, data_sram_rdata, data_sram_data_ok, WB_allowin,
      output MEM_allowin, MEM_to_WB_valid, MEM_to_WB_BUS, MEM_RF_BUS
   );

endinterface
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_align : selects byte/halfword/word from load data and extends it       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr,
   input  logic [3:0]  i_load_op,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_zext;

   always_comb begin
      w_byte = 8'h00;
      case (i_addr)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
   end

   // Halfwords are assumed aligned; address bit 0 plays no part.
   assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
   assign w_zext = i_load_op[c_LD_ZEXT];

   always_comb begin
      o_result = i_rdata;
      if (i_load_op[c_LD_BYTE]) begin
         o_result = {{24{~w_zext & w_byte[7]}}, w_byte};
      end else if (i_load_op[c_LD_HALF]) begin
         o_result = {{16{~w_zext & w_half[15]}}, w_half};
      end else if (i_load_op[c_LD_WORD]) begin
         o_result = i_rdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage : pipeline MEM stage, waits on data SRAM and buffers responses    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   mem_stage_if.slave mem_bus
);

   exe_to_mem_t         r_bus;
   exe_to_mem_t         w_in;
   mem_state_t          r_state;
   mem_state_t          w_state_nxt;
   logic [31:0]         r_buf_data;

   logic                w_valid;
   logic                w_buf_valid;
   logic                w_ready_go;
   logic                w_allowin;
   logic                w_buf_load;
   logic                w_capture;
   logic [31:0]         w_load_src;
   logic [31:0]         w_load_val;
   logic [31:0]         w_final_result;
   logic [DEST_LEN-1:0] w_rf_dest;
   logic                w_load_pending;
   logic                w_unused;

   assign w_in        = exe_to_mem_t'(mem_bus.EXE_to_MEM_BUS);
   assign w_valid     = (r_state != S_IDLE);
   assign w_buf_valid = (r_state == S_HOLD);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // data_ok is only honoured in WAIT; in IDLE or HOLD it falls through untouched.
   always_comb begin
      w_state_nxt = r_state;
      w_ready_go  = 1'b0;
      w_allowin   = 1'b1;
      w_buf_load  = 1'b0;
      case (r_state)
         S_DONE,
         S_HOLD:  w_ready_go = 1'b1;
         S_WAIT:  w_ready_go = mem_bus.data_sram_data_ok;
         default: w_ready_go = 1'b0;
      endcase
      w_allowin = !w_valid || (w_ready_go && mem_bus.WB_allowin);
      if (w_allowin) begin
         if (mem_bus.EXE_to_MEM_valid) begin
            w_state_nxt = is_mem_op(w_in) ? S_WAIT : S_DONE;
         end else begin
            w_state_nxt = S_IDLE;
         end
      end else if ((r_state == S_WAIT) && mem_bus.data_sram_data_ok) begin
         w_state_nxt = S_HOLD;
         w_buf_load  = 1'b1;
      end
   end

   assign w_capture = mem_bus.EXE_to_MEM_valid && w_allowin;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bus      <= '0;
         r_buf_data <= '0;
      end else begin
         if (w_capture) begin
            r_bus <= w_in;
         end
         if (w_buf_load) begin
            r_buf_data <= mem_bus.data_sram_rdata;
         end
      end
   end

   // Once buffered, the live SRAM data may change freely without disturbing WB.
   assign w_load_src = w_buf_valid ? r_buf_data : mem_bus.data_sram_rdata;

   load_align u_load_align (
      .i_rdata   (w_load_src),
      .i_addr    (r_bus.alu_result[1:0]),
      .i_load_op (r_bus.load_op),
      .o_result  (w_load_val)
   );

   assign w_final_result = r_bus.rfrom_mem ? w_load_val : r_bus.alu_result;
   assign w_load_pending = w_valid && r_bus.rfrom_mem && !w_ready_go;
   assign w_rf_dest      = r_bus.dest & {DEST_LEN{r_bus.gr_we & w_valid}};

   assign mem_bus.MEM_allowin     = w_allowin;
   assign mem_bus.MEM_to_WB_valid = w_valid && w_ready_go;
   assign mem_bus.MEM_to_WB_BUS   = {r_bus.pc, r_bus.gr_we, r_bus.dest, w_final_result};
   assign mem_bus.MEM_RF_BUS      = {w_rf_dest, w_load_pending, w_final_result};

   // Store-side fields travel with the instruction but are consumed elsewhere.
   assign w_unused = ^{r_bus.mem_sum, r_bus.mem_we, r_bus.mem_en};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_stage : directed + randomized bench with an instruction-level model  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mem_stage;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   mem_stage_if mif ();

   mem_stage dut (
      .clk     (clk),
      .reset   (reset),
      .mem_bus (mif.slave)
   );

   // ---------------- instruction helpers ----------------
   function automatic logic [111:0] make_ins(input logic [31:0] pc, input logic gr_we,
                                             input logic [4:0] dest, input logic [31:0] alu,
                                             input logic mem_en, input logic [3:0] mem_we,
                                             input logic [3:0] load_op, input logic rfrom);
      return {pc, gr_we, dest, alu, alu, mem_en, mem_we, load_op, rfrom};
   endfunction

   function automatic logic [31:0] f_pc(input logic [111:0] i);   return i[111:80]; endfunction
   function automatic logic        f_we(input logic [111:0] i);   return i[79];     endfunction
   function automatic logic [4:0]  f_dest(input logic [111:0] i); return i[78:74];  endfunction
   function automatic logic [31:0] f_alu(input logic [111:0] i);  return i[73:42];  endfunction
   function automatic logic [3:0]  f_op(input logic [111:0] i);   return i[4:1];    endfunction
   function automatic logic        f_rfm(input logic [111:0] i);  return i[0];      endfunction
   function automatic logic        f_mem(input logic [111:0] i);  return i[9] | i[0]; endfunction

   function automatic logic [31:0] load_value(input logic [3:0] op, input logic [31:0] addr,
                                              input logic [31:0] d);
      logic [31:0] v;
      int          sh;
      if (op[0]) begin
         sh = 8 * int'(addr[1:0]);
         v  = (d >> sh) & 32'h0000_00FF;
         if (!op[3] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (op[1]) begin
         sh = 16 * int'(addr[1]);
         v  = (d >> sh) & 32'h0000_FFFF;
         if (!op[3] && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   function automatic logic [31:0] expect_final(input logic [111:0] i, input logic [31:0] d);
      return f_rfm(i) ? load_value(f_op(i), f_alu(i), d) : f_alu(i);
   endfunction

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: one instruction slot ----------------
   logic           m_valid = 1'b0;
   logic           m_got   = 1'b0;
   logic [111:0]   m_ins   = '0;
   logic [31:0]    m_data  = '0;
   int             retired = 0;

   always @(posedge clk) begin : model
      logic ready;
      if (reset) begin
         m_valid <= 1'b0;
         m_got   <= 1'b0;
      end else begin
         ready = m_valid && (!f_mem(m_ins) || m_got || mif.data_sram_data_ok);
         if (!m_valid || (ready && mif.WB_allowin)) begin
            if (m_valid) retired <= retired + 1;
            m_valid <= mif.EXE_to_MEM_valid;
            m_got   <= 1'b0;
            if (mif.EXE_to_MEM_valid) m_ins <= mif.EXE_to_MEM_BUS;
         end else if (f_mem(m_ins) && !m_got && mif.data_sram_data_ok) begin
            m_got  <= 1'b1;
            m_data <= mif.data_sram_rdata;
         end
      end
   end

   always @(negedge clk) begin : compare
      logic        e_ready;
      logic [31:0] e_final;
      if (!reset) begin
         e_ready = m_valid && (!f_mem(m_ins) || m_got || mif.data_sram_data_ok);
         check("allowin", 70'(mif.MEM_allowin), 70'(!m_valid || (e_ready && mif.WB_allowin)));
         check("to_wb_valid", 70'(mif.MEM_to_WB_valid), 70'(e_ready));
         check("load_pending", 70'(mif.MEM_RF_BUS[32]), 70'(m_valid && f_rfm(m_ins) && !e_ready));
         check("rf_dest", 70'(mif.MEM_RF_BUS[37:33]),
               70'((m_valid && f_we(m_ins)) ? f_dest(m_ins) : 5'd0));
         if (m_valid) begin
            e_final = expect_final(m_ins, m_got ? m_data : mif.data_sram_rdata);
            check("rf_final", 70'(mif.MEM_RF_BUS[31:0]), 70'(e_final));
            if (e_ready)
               check("wb_bus", mif.MEM_to_WB_BUS,
                     {f_pc(m_ins), f_we(m_ins), f_dest(m_ins), e_final});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(); @(posedge clk); #1; endtask
   task automatic mid();  @(negedge clk);     endtask

   task automatic directed_load(input string nm, input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] rd, input logic [31:0] exp, input int wait_cyc);
      tick();
      mif.EXE_to_MEM_BUS   = make_ins(32'h0000_4000, 1'b1, 5'd9, addr, 1'b1, 4'h0, op, 1'b1);
      mif.EXE_to_MEM_valid = 1'b1;
      mif.WB_allowin       = 1'b1;
      mif.data_sram_data_ok = 1'b0;
      tick();
      mif.EXE_to_MEM_valid = 1'b0;
      for (int k = 0; k < wait_cyc; k++) begin
         mid();
         check({nm, "_pending"}, 70'(mif.MEM_RF_BUS[32]), 70'd1);
         tick();
      end
      mif.data_sram_data_ok = 1'b1;
      mif.data_sram_rdata   = rd;
      mid();
      check({nm, "_valid"}, 70'(mif.MEM_to_WB_valid), 70'd1);
      check({nm, "_final"}, 70'(mif.MEM_to_WB_BUS[31:0]), 70'(exp));
      tick();
      mif.data_sram_data_ok = 1'b0;
      mif.data_sram_rdata   = 32'h5555_AAAA;
   endtask

   logic [3:0] ld_ops [5] = '{4'b0001, 4'b1001, 4'b0010, 4'b1010, 4'b0100};

   initial begin
      mif.EXE_to_MEM_BUS    = '0;
      mif.EXE_to_MEM_valid  = 1'b0;
      mif.data_sram_rdata   = '0;
      mif.data_sram_data_ok = 1'b0;
      mif.WB_allowin        = 1'b1;

      // reset state
      repeat (3) tick();
      mid();
      check("rst_allowin", 70'(mif.MEM_allowin), 70'd1);
      check("rst_to_wb", 70'(mif.MEM_to_WB_valid), 70'd0);
      check("rst_rf_bus", 70'(mif.MEM_RF_BUS), 70'd0);
      tick();
      reset = 1'b0;

      // ALU op: single-cycle pass-through
      tick();
      mif.EXE_to_MEM_BUS   = make_ins(32'h0000_1000, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 4'h0, 4'h0, 1'b0);
      mif.EXE_to_MEM_valid = 1'b1;
      tick();
      mif.EXE_to_MEM_valid = 1'b0;
      mid();
      check("alu_valid", 70'(mif.MEM_to_WB_valid), 70'd1);
      check("alu_final", 70'(mif.MEM_to_WB_BUS[31:0]), 70'h1234_5678);
      check("alu_rf_dest", 70'(mif.MEM_RF_BUS[37:33]), 70'd5);

      // store passes address-independent alu_result
      tick();
      mif.EXE_to_MEM_BUS   = make_ins(32'h0000_1004, 1'b0, 5'd0, 32'hA5A5_0004, 1'b1, 4'hF, 4'h0, 1'b0);
      mif.EXE_to_MEM_valid = 1'b1;
      tick();
      mif.EXE_to_MEM_valid  = 1'b0;
      mif.data_sram_data_ok = 1'b1;
      mid();
      check("st_final", 70'(mif.MEM_to_WB_BUS[31:0]), 70'hA5A5_0004);
      tick();
      mif.data_sram_data_ok = 1'b0;

      directed_load("lw",  4'b0100, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2);
      directed_load("lb",  4'b0001, 32'h0000_0101, 32'h0000_8000, 32'hFFFF_FF80, 0);
      directed_load("lbu", 4'b1001, 32'h0000_0101, 32'h0000_8000, 32'h0000_0080, 1);
      directed_load("lhu", 4'b1010, 32'h0000_0102, 32'hBEEF_1234, 32'h0000_BEEF, 0);
      directed_load("lh",  4'b0010, 32'h0000_0102, 32'hBEEF_1234, 32'hFFFF_BEEF, 0);

      // WB stall across the response; later rdata changes and a stray data_ok must not leak in
      tick();
      mif.EXE_to_MEM_BUS   = make_ins(32'h0000_2000, 1'b1, 5'd7, 32'h0000_0200, 1'b1, 4'h0, 4'b0100, 1'b1);
      mif.EXE_to_MEM_valid = 1'b1;
      tick();
      mif.EXE_to_MEM_valid  = 1'b0;
      mif.WB_allowin        = 1'b0;
      mif.data_sram_data_ok = 1'b1;
      mif.data_sram_rdata   = 32'hCAFE_F00D;
      mid();
      check("hold_valid0", 70'(mif.MEM_to_WB_valid), 70'd1);
      check("hold_allow0", 70'(mif.MEM_allowin), 70'd0);
      tick();
      mif.data_sram_data_ok = 1'b0;
      mif.data_sram_rdata   = 32'h1111_1111;
      mid();
      check("hold_final1", 70'(mif.MEM_to_WB_BUS[31:0]), 70'hCAFE_F00D);
      tick();
      mif.data_sram_data_ok = 1'b1;
      mif.data_sram_rdata   = 32'h2222_2222;
      mid();
      check("hold_final2", 70'(mif.MEM_to_WB_BUS[31:0]), 70'hCAFE_F00D);
      tick();
      mif.data_sram_data_ok = 1'b0;
      mif.WB_allowin        = 1'b1;
      mid();
      check("hold_release", 70'(mif.MEM_to_WB_BUS[31:0]), 70'hCAFE_F00D);
      check("hold_allow3", 70'(mif.MEM_allowin), 70'd1);
      tick();
      mid();
      check("hold_left", 70'(mif.MEM_to_WB_valid), 70'd0);

      // reset while waiting, stale data_ok afterwards
      tick();
      mif.EXE_to_MEM_BUS   = make_ins(32'h0000_3000, 1'b1, 5'd3, 32'h0000_0300, 1'b1, 4'h0, 4'b0100, 1'b1);
      mif.EXE_to_MEM_valid = 1'b1;
      tick();
      mif.EXE_to_MEM_valid = 1'b0;
      mid();
      check("rw_pending", 70'(mif.MEM_RF_BUS[32]), 70'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mif.data_sram_data_ok = 1'b1;
      mif.data_sram_rdata   = 32'hBAD0_BAD0;
      mid();
      check("rw_to_wb", 70'(mif.MEM_to_WB_valid), 70'd0);
      check("rw_allowin", 70'(mif.MEM_allowin), 70'd1);
      check("rw_rf_bus", 70'(mif.MEM_RF_BUS), 70'd0);
      tick();
      mif.data_sram_data_ok = 1'b0;
      mid();
      check("rw_to_wb2", 70'(mif.MEM_to_WB_valid), 70'd0);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int          kind;
         logic [3:0]  op;
         logic [31:0] alu;
         tick();
         reset = ($urandom_range(0, 199) == 0);
         kind  = $urandom_range(0, 2);
         op    = ld_ops[$urandom_range(0, 4)];
         alu   = $urandom;
         case (kind)
            0:       mif.EXE_to_MEM_BUS = make_ins($urandom, 1'($urandom), 5'($urandom), alu,
                                                   1'b0, 4'h0, 4'h0, 1'b0);
            1:       mif.EXE_to_MEM_BUS = make_ins($urandom, 1'b0, 5'($urandom), alu,
                                                   1'b1, 4'($urandom_range(1, 15)), 4'h0, 1'b0);
            default: mif.EXE_to_MEM_BUS = make_ins($urandom, 1'($urandom), 5'($urandom), alu,
                                                   1'b1, 4'h0, op, 1'b1);
         endcase
         mif.EXE_to_MEM_valid = 1'($urandom_range(0, 1));
         mif.WB_allowin       = ($urandom_range(0, 3) != 0);
         mif.data_sram_rdata  = $urandom;
         if (m_valid && f_mem(m_ins) && !m_got)
            mif.data_sram_data_ok = ($urandom_range(0, 2) == 0);
         else if (!m_valid || m_got)
            mif.data_sram_data_ok = ($urandom_range(0, 7) == 0);
         else
            mif.data_sram_data_ok = 1'b0;
      end

      tick();
      reset                 = 1'b0;
      mif.EXE_to_MEM_valid  = 1'b0;
      mif.data_sram_data_ok = 1'b0;
      mif.WB_allowin        = 1'b1;
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have no parameters; all bus widths SHALL come from the shared header (see Structure).
REQ-002 clk  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 EXE_to_MEM_BUS  in  112  {exe_pc[31:0], gr_we, dest[4:0], alu_result[31:0], mem_sum[31:0], mem_en, mem_we[3:0], load_op[3:0], rfrom_mem}.
REQ-005 EXE_to_MEM_valid  in  1  upstream instruction valid.
REQ-006 MEM_allowin  out  1  stage can accept a new instruction.
REQ-007 data_sram_rdata  in  32  load data, valid with data_sram_data_ok.
REQ-008 data_sram_data_ok  in  1  one-cycle pulse: outstanding access completed.
REQ-009 WB_allowin  in  1  downstream can accept.
REQ-010 MEM_to_WB_valid  out  1  instruction ready to leave.
REQ-011 MEM_to_WB_BUS  out  70  {mem_pc[31:0], gr_we, dest[4:0], final_result[31:0]}.
REQ-012 MEM_RF_BUS  out  38  {dest masked by gr_we&MEM_valid [4:0], load_pending, final_result[31:0]} for ID forwarding/stall.

Function
REQ-013 Handshake SHALL be: MEM_allowin = !MEM_valid || (MEM_ready_go && WB_allowin); MEM_to_WB_valid = MEM_valid && MEM_ready_go.
REQ-014 MEM_valid SHALL load EXE_to_MEM_valid whenever MEM_allowin=1; bus register SHALL capture EXE_to_MEM_BUS only when EXE_to_MEM_valid && MEM_allowin.
REQ-015 An instruction with rfrom_mem=0 and mem_en=0 SHALL be ready_go in the cycle it is valid (1-cycle latency), final_result = alu_result.
REQ-016 A memory instruction (rfrom_mem|mem_en) SHALL be ready_go only when data_sram_data_ok=1 this cycle or the data buffer holds its response.
REQ-017 States per instruction: IDLE (no valid), WAIT (mem op, no data_ok yet), HOLD (data_ok received, buffered, WB stalling), DONE (leaving); WAIT->HOLD on data_ok && !WB_allowin; WAIT->leave on data_ok && WB_allowin; HOLD->leave on WB_allowin.
REQ-018 On data_ok with WB_allowin=0 the block SHALL latch rdata into a 32-bit buffer and set buf_valid; buf_valid SHALL clear when the instruction leaves (MEM_to_WB_valid && WB_allowin).
REQ-019 data_ok arriving while MEM_valid=0 or while buf_valid=1 SHALL be ignored.
REQ-020 load_op bits SHALL mean: [0] byte, [1] halfword, [2] word, [3] zero-extend (else sign-extend); exactly one of [2:0] set for loads.
REQ-021 Byte select SHALL use alu_result[1:0] (0..3 -> rdata[7:0]..[31:24]); halfword select SHALL use alu_result[1] (0 -> [15:0], 1 -> [31:16]); alu_result[0] ignored for halfwords.
REQ-022 For rfrom_mem=1, final_result SHALL be the extended load value from buffer (if buf_valid) else live rdata; stores (mem_en=1, rfrom_mem=0) SHALL pass alu_result.
REQ-023 load_pending SHALL equal MEM_valid && rfrom_mem && !MEM_ready_go.
REQ-024 Outputs SHALL stay stable while MEM_to_WB_valid=1 and WB_allowin=0.

Reset
REQ-025 On reset MEM_valid, buf_valid, buffer and bus register SHALL clear to 0; hence MEM_to_WB_valid=0, MEM_allowin=1, MEM_RF_BUS=0.
REQ-026 Reset during WAIT or HOLD SHALL discard the instruction; a later stale data_ok SHALL be ignored per REQ-019.

Structure
REQ-027 Bus widths (EXE_to_MEM_LEN=112, MEM_to_WB_LEN=70, MEM_RF_LEN=38, DEST_LEN=5) and load_op bit positions SHALL live in the shared header.
REQ-028 Load alignment/extension SHALL be one combinational sub-module, load_align.

Verification
REQ-029 ALU op, alu_result=0x12345678, WB_allowin=1 -> MEM_to_WB_valid next cycle after capture, final_result=0x12345678.
REQ-030 LW addr 0x100, data_ok 2 cycles after capture with rdata=0xDEADBEEF -> load_pending=1 for 2 cycles, then final_result=0xDEADBEEF.
REQ-031 LB addr 0x101, rdata=0x00008000 -> final_result=0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 LHU addr 0x102, rdata=0xBEEF1234 -> final_result=0x0000BEEF; LH -> 0xFFFFBEEF.
REQ-033 LW with data_ok while WB_allowin=0 for 3 cycles, rdata changed afterwards -> outputs held, final_result equals captured rdata, leaves when WB_allowin=1.
REQ-034 Reset asserted in WAIT, data_ok pulses cycle after release -> MEM_to_WB_valid stays 0, MEM_allowin=1.
